// File: rtl/layer_pkg.sv
// Shared definitions for the layer compositor: config field codes, CTRL bit
// positions and the per-layer record held in the shadow and active banks.
package layer_pkg;

    localparam int unsigned CFG_DATA_W = 16;
    localparam int unsigned REC_COORD_W = 16;
    localparam int unsigned RGB_W = 12;
    localparam int unsigned THICK_W = 4;
    localparam int unsigned FIELD_W = 3;

    localparam int unsigned CTRL_EN_BIT = 0;
    localparam int unsigned CTRL_OUTLINE_BIT = 1;
    localparam int unsigned CTRL_THICK_LSB = 4;

    typedef enum logic [FIELD_W-1:0] {
        FLD_X0    = 3'd0,
        FLD_Y0    = 3'd1,
        FLD_X1    = 3'd2,
        FLD_Y1    = 3'd3,
        FLD_COLOR = 3'd4,
        FLD_CTRL  = 3'd5
    } cfg_field_e;

    typedef struct packed {
        logic [REC_COORD_W-1:0] x0;
        logic [REC_COORD_W-1:0] y0;
        logic [REC_COORD_W-1:0] x1;
        logic [REC_COORD_W-1:0] y1;
        logic [RGB_W-1:0]       color;
        logic                   enable;
        logic                   outline;
        logic [THICK_W-1:0]     thick;
    } layer_t;

    // Apply one config write to a layer record; codes 6-7 leave it unchanged.
    function automatic layer_t write_field(input layer_t cur,
                                           input logic [FIELD_W-1:0] fld,
                                           input logic [CFG_DATA_W-1:0] data);
        layer_t nxt;
        nxt = cur;
        case (fld)
            FLD_X0:    nxt.x0 = data;
            FLD_Y0:    nxt.y0 = data;
            FLD_X1:    nxt.x1 = data;
            FLD_Y1:    nxt.y1 = data;
            FLD_COLOR: nxt.color = data[RGB_W-1:0];
            FLD_CTRL: begin
                nxt.enable  = data[CTRL_EN_BIT];
                nxt.outline = data[CTRL_OUTLINE_BIT];
                nxt.thick   = data[CTRL_THICK_LSB +: THICK_W];
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rect_hit.sv
// Single-layer hit test (combinational).
//   i_layer : layer record from the active bank
//   i_x/i_y : pixel coordinate
//   o_hit_c : filled hit, or outline-ring hit when the outline bit is set
// Layer coordinates are truncated to COORD_W (COORD_W <= 16).
module rect_hit
    import layer_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  layer_t             i_layer,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_hit_c
);

    logic [COORD_W-1:0] w_x0, w_y0, w_x1, w_y1, w_t;
    logic [COORD_W-1:0] w_ex0, w_ey0, w_ex1, w_ey1;
    logic [COORD_W:0]   w_sum_x, w_sum_y;
    logic               w_in_box, w_in_outer;

    // Box test plus saturating T-expansion (no wrap at 0 or at all-ones).
    always_comb begin
        o_hit_c = 1'b0;
        w_x0 = COORD_W'(i_layer.x0);
        w_y0 = COORD_W'(i_layer.y0);
        w_x1 = COORD_W'(i_layer.x1);
        w_y1 = COORD_W'(i_layer.y1);
        w_t  = COORD_W'(i_layer.thick);

        w_in_box = (i_x >= w_x0) && (i_x <= w_x1) && (i_y >= w_y0) && (i_y <= w_y1);

        w_ex0 = (w_x0 >= w_t) ? (w_x0 - w_t) : '0;
        w_ey0 = (w_y0 >= w_t) ? (w_y0 - w_t) : '0;
        w_sum_x = {1'b0, w_x1} + {1'b0, w_t};
        w_sum_y = {1'b0, w_y1} + {1'b0, w_t};
        w_ex1 = w_sum_x[COORD_W] ? '1 : w_sum_x[COORD_W-1:0];
        w_ey1 = w_sum_y[COORD_W] ? '1 : w_sum_y[COORD_W-1:0];

        w_in_outer = (i_x >= w_ex0) && (i_x <= w_ex1) && (i_y >= w_ey0) && (i_y <= w_ey1);

        if (i_layer.enable) begin
            if (i_layer.outline) begin
                o_hit_c = (w_t != '0) && w_in_outer && !w_in_box;
            end else begin
                o_hit_c = w_in_box;
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Rectangle layer compositor for a VGA pixel stream.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_pix_stb                    : pipeline advance strobe
//   i_x, i_y, i_active           : pixel coordinate and visible flag
//   i_end_of_frame               : last pixel of frame (shadow -> active copy)
//   i_cfg_*, o_cfg_ready         : layer field write handshake into shadow bank
//   o_red/o_green/o_blue         : composited colour, 2 strobes after input
//   o_hit, o_hit_layer           : any-layer hit and winning (lowest) index
module layer_compositor
    import layer_pkg::*;
#(
    parameter int unsigned N_LAYERS = 8,
    parameter int unsigned COORD_W  = 16,
    parameter logic [11:0] BG_RGB   = 12'h000,
    localparam int unsigned LAYER_W = $clog2(N_LAYERS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pix_stb,
    input  logic [COORD_W-1:0]    i_x,
    input  logic [COORD_W-1:0]    i_y,
    input  logic                  i_active,
    input  logic                  i_end_of_frame,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [LAYER_W-1:0]    i_cfg_layer,
    input  logic [FIELD_W-1:0]    i_cfg_field,
    input  logic [CFG_DATA_W-1:0] i_cfg_data,
    output logic [3:0]            o_red,
    output logic [3:0]            o_green,
    output logic [3:0]            o_blue,
    output logic                  o_hit,
    output logic [LAYER_W-1:0]    o_hit_layer
);

    layer_t               r_shadow [N_LAYERS];
    layer_t               r_active [N_LAYERS];
    logic [N_LAYERS-1:0]  w_hits;
    logic [N_LAYERS-1:0]  r_s1_hits;
    logic                 r_s1_active;
    logic [RGB_W-1:0]     r_rgb;
    logic                 r_hit;
    logic [LAYER_W-1:0]   r_hit_layer;
    logic                 w_swap, w_cfg_wr, w_any;
    logic [LAYER_W-1:0]   w_win;
    logic [RGB_W-1:0]     w_rgb_nxt;

    // Config is refused only on the bank-copy cycle so no write is lost in it.
    assign w_swap      = i_pix_stb & i_end_of_frame;
    assign o_cfg_ready = ~i_rst & ~w_swap;
    assign w_cfg_wr    = i_cfg_valid & o_cfg_ready;

    // Shadow bank takes writes; active bank is refreshed whole at frame end.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int l = 0; l < N_LAYERS; l++) begin
                r_shadow[l] <= '0;
                r_active[l] <= '0;
            end
        end else begin
            for (int l = 0; l < N_LAYERS; l++) begin
                if (w_cfg_wr && (i_cfg_layer == LAYER_W'(l))) begin
                    r_shadow[l] <= write_field(r_shadow[l], i_cfg_field, i_cfg_data);
                end
                if (w_swap) begin
                    r_active[l] <= r_shadow[l];
                end
            end
        end
    end

    for (genvar g = 0; g < N_LAYERS; g++) begin : g_hit
        rect_hit #(.COORD_W(COORD_W)) u_rect_hit (
            .i_layer (r_active[g]),
            .i_x     (i_x),
            .i_y     (i_y),
            .o_hit_c (w_hits[g])
        );
    end

    // Lowest index wins: scan downward so the last assignment is the lowest.
    // Colour comes from the active bank; the copy happens on the frame-end
    // pixel, which sits in blanking, so no visible pixel straddles it.
    always_comb begin
        w_any     = 1'b0;
        w_win     = '0;
        w_rgb_nxt = '0;
        for (int l = N_LAYERS - 1; l >= 0; l--) begin
            if (r_s1_hits[l]) begin
                w_any = 1'b1;
                w_win = LAYER_W'(l);
            end
        end
        if (r_s1_active) begin
            w_rgb_nxt = w_any ? r_active[w_win].color : BG_RGB;
        end
    end

    // Two strobe-qualified stages: hit flags, then priority/colour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_hits   <= '0;
            r_s1_active <= 1'b0;
            r_rgb       <= '0;
            r_hit       <= 1'b0;
            r_hit_layer <= '0;
        end else if (i_pix_stb) begin
            r_s1_hits   <= w_hits;
            r_s1_active <= i_active;
            r_rgb       <= w_rgb_nxt;
            r_hit       <= r_s1_active & w_any;
            r_hit_layer <= r_s1_active ? w_win : '0;
        end
    end

    assign o_red       = r_rgb[11:8];
    assign o_green     = r_rgb[7:4];
    assign o_blue      = r_rgb[3:0];
    assign o_hit       = r_hit;
    assign o_hit_layer = r_hit_layer;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: table of probe pixels plus sequences
// for frame-boundary, handshake and reset behaviour.
module tb_layer_compositor;

    localparam int unsigned N  = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_pix_stb = 1'b0;
    logic [CW-1:0] i_x = '0;
    logic [CW-1:0] i_y = '0;
    logic          i_active = 1'b0;
    logic          i_end_of_frame = 1'b0;
    logic          i_cfg_valid = 1'b0;
    logic          o_cfg_ready;
    logic [LW-1:0] i_cfg_layer = '0;
    logic [2:0]    i_cfg_field = '0;
    logic [15:0]   i_cfg_data = '0;
    logic [3:0]    o_red, o_green, o_blue;
    logic          o_hit;
    logic [LW-1:0] o_hit_layer;

    always #5 clk = ~clk;

    layer_compositor #(.N_LAYERS(N), .COORD_W(CW), .BG_RGB(12'h135)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_pix_stb      (i_pix_stb),
        .i_x            (i_x),
        .i_y            (i_y),
        .i_active       (i_active),
        .i_end_of_frame (i_end_of_frame),
        .i_cfg_valid    (i_cfg_valid),
        .o_cfg_ready    (o_cfg_ready),
        .i_cfg_layer    (i_cfg_layer),
        .i_cfg_field    (i_cfg_field),
        .i_cfg_data     (i_cfg_data),
        .o_red          (o_red),
        .o_green        (o_green),
        .o_blue         (o_blue),
        .o_hit          (o_hit),
        .o_hit_layer    (o_hit_layer)
    );

    // Observed word: {hit, hit_layer[2:0], R, G, B}
    logic [15:0] obs;
    assign obs = {o_hit, o_hit_layer, o_red, o_green, o_blue};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One strobe cycle followed by one idle cycle (exercises output hold).
    task automatic strobe(input logic [15:0] x, input logic [15:0] y,
                          input logic act, input logic eof);
        i_x = x; i_y = y; i_active = act; i_end_of_frame = eof; i_pix_stb = 1'b1;
        tick();
        i_pix_stb = 1'b0; i_end_of_frame = 1'b0; i_active = 1'b0;
        tick();
    endtask

    task automatic probe(input logic [15:0] x, input logic [15:0] y, input logic act,
                         input logic [15:0] exp, input string name);
        strobe(x, y, act, 1'b0);
        strobe(16'd0, 16'd0, 1'b0, 1'b0);
        check(name, obs, exp);
    endtask

    task automatic frame();
        strobe(16'd0, 16'd0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [2:0] l, input logic [2:0] f, input logic [15:0] d);
        i_cfg_valid = 1'b1; i_cfg_layer = l; i_cfg_field = f; i_cfg_data = d;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    task automatic cfg_layer(input logic [2:0] l, input logic [15:0] x0, input logic [15:0] y0,
                             input logic [15:0] x1, input logic [15:0] y1,
                             input logic [15:0] color, input logic [15:0] ctrl);
        wr(l, 3'd0, x0); wr(l, 3'd1, y0); wr(l, 3'd2, x1); wr(l, 3'd3, y1);
        wr(l, 3'd4, color); wr(l, 3'd5, ctrl);
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        act;
        logic [15:0] exp;
        string       name;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{16'd100,   16'd100,  1'b1, 16'h8F00, "l0_corner_tl"};
        vecs[1]  = '{16'd200,   16'd150,  1'b1, 16'h8F00, "l0_corner_br"};
        vecs[2]  = '{16'd201,   16'd100,  1'b1, 16'h0135, "l0_right_out"};
        vecs[3]  = '{16'd100,   16'd151,  1'b1, 16'h0135, "l0_below_out"};
        vecs[4]  = '{16'd50,    16'd50,   1'b1, 16'h90F0, "overlap_l1_wins"};
        vecs[5]  = '{16'd65,    16'd65,   1'b1, 16'hB00F, "l3_only"};
        vecs[6]  = '{16'd240,   16'd230,  1'b1, 16'hA0FF, "outline_ring"};
        vecs[7]  = '{16'd245,   16'd230,  1'b1, 16'h0135, "outline_inner"};
        vecs[8]  = '{16'd239,   16'd230,  1'b1, 16'h0135, "outline_beyond"};
        vecs[9]  = '{16'd400,   16'd385,  1'b1, 16'hA0FF, "outline_outer_corner"};
        vecs[10] = '{16'd401,   16'd385,  1'b1, 16'h0135, "outline_outer_out"};
        vecs[11] = '{16'd0,     16'd305,  1'b1, 16'hCFF0, "sat_low_x0"};
        vecs[12] = '{16'd3,     16'd305,  1'b1, 16'h0135, "sat_low_inner"};
        vecs[13] = '{16'd65535, 16'd1005, 1'b1, 16'hE123, "sat_high_x1"};
        vecs[14] = '{16'd0,     16'd1005, 1'b1, 16'h0135, "sat_high_nowrap"};
        vecs[15] = '{16'd45,    16'd10,   1'b1, 16'h0135, "inverted_box"};
        vecs[16] = '{16'd505,   16'd405,  1'b1, 16'h0135, "outline_t0"};
        vecs[17] = '{16'd100,   16'd100,  1'b0, 16'h0000, "inactive_zero"};

        // Reset state
        tick(); tick();
        check("rst_ready", 16'(o_cfg_ready), 16'd0);
        check("rst_outputs", obs, 16'h0000);
        i_rst = 1'b0;
        #1;
        check("ready_after_rst", 16'(o_cfg_ready), 16'd1);
        tick();

        cfg_layer(3'd0, 16'd100, 16'd100, 16'd200, 16'd150, 16'h0F00, 16'h0001);
        cfg_layer(3'd1, 16'd40, 16'd40, 16'd60, 16'd60, 16'h00F0, 16'h0001);
        cfg_layer(3'd2, 16'd245, 16'd230, 16'd395, 16'd380, 16'h00FF, 16'h0053);
        cfg_layer(3'd3, 16'd45, 16'd45, 16'd70, 16'd70, 16'h000F, 16'h0001);
        cfg_layer(3'd4, 16'd2, 16'd300, 16'd10, 16'd310, 16'h0FF0, 16'h0053);
        cfg_layer(3'd5, 16'd50, 16'd0, 16'd40, 16'd479, 16'h0888, 16'h0001);
        cfg_layer(3'd6, 16'd65530, 16'd1000, 16'd65534, 16'd1010, 16'h0123, 16'h0033);
        cfg_layer(3'd7, 16'd500, 16'd400, 16'd510, 16'd410, 16'h0777, 16'h0003);
        wr(3'd0, 3'd6, 16'hFFFF);
        wr(3'd0, 3'd7, 16'h0000);

        // Shadow writes are invisible until the frame boundary
        probe(16'd100, 16'd100, 1'b1, 16'h0135, "pre_boundary_bg");
        frame();

        for (int i = 0; i < NV; i++) begin
            probe(vecs[i].x, vecs[i].y, vecs[i].act, vecs[i].exp, vecs[i].name);
        end

        // Exact two-strobe latency and hold between strobes
        strobe(16'd100, 16'd100, 1'b1, 1'b0);
        check("latency_1strobe", obs, 16'h0000);
        strobe(16'd0, 16'd0, 1'b0, 1'b0);
        check("latency_2strobe", obs, 16'h8F00);
        tick(); tick(); tick();
        check("hold_idle", obs, 16'h8F00);

        // Disabling layer 1 takes effect only after the next boundary
        wr(3'd1, 3'd5, 16'h0000);
        probe(16'd50, 16'd50, 1'b1, 16'h90F0, "disable_pending");
        frame();
        probe(16'd50, 16'd50, 1'b1, 16'hB00F, "disable_applied");

        // Write held across the bank-copy cycle
        i_cfg_valid = 1'b1; i_cfg_layer = 3'd0; i_cfg_field = 3'd4; i_cfg_data = 16'h00AB;
        i_pix_stb = 1'b1; i_end_of_frame = 1'b1; i_active = 1'b0;
        #1;
        check("ready_low_on_copy", 16'(o_cfg_ready), 16'd0);
        @(posedge clk); #1;
        i_pix_stb = 1'b0; i_end_of_frame = 1'b0;
        #1;
        check("ready_high_after_copy", 16'(o_cfg_ready), 16'd1);
        @(posedge clk); #1;
        i_cfg_valid = 1'b0;
        probe(16'd100, 16'd100, 1'b1, 16'h8F00, "held_write_not_yet");
        frame();
        probe(16'd100, 16'd100, 1'b1, 16'h80AB, "held_write_shown");

        // Mid-frame reset with pending shadow writes, write and bank copy
        wr(3'd2, 3'd5, 16'h0001);
        wr(3'd1, 3'd5, 16'h0001);
        strobe(16'd100, 16'd100, 1'b1, 1'b0);
        strobe(16'd100, 16'd100, 1'b1, 1'b0);
        check("pre_reset_output", obs, 16'h80AB);
        i_cfg_valid = 1'b1; i_cfg_layer = 3'd0; i_cfg_field = 3'd5; i_cfg_data = 16'h0001;
        i_pix_stb = 1'b1; i_end_of_frame = 1'b1; i_rst = 1'b1;
        #1;
        check("ready_in_reset", 16'(o_cfg_ready), 16'd0);
        @(posedge clk); #1;
        check("reset_outputs", obs, 16'h0000);
        i_rst = 1'b0; i_cfg_valid = 1'b0; i_pix_stb = 1'b0; i_end_of_frame = 1'b0;
        #1;
        check("ready_after_midrst", 16'(o_cfg_ready), 16'd1);
        tick();
        frame();
        probe(16'd100, 16'd100, 1'b1, 16'h0135, "post_rst_l0_bg");
        probe(16'd50, 16'd50, 1'b1, 16'h0135, "post_rst_l1_bg");
        probe(16'd240, 16'd230, 1'b1, 16'h0135, "post_rst_l2_bg");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
